// File: rtl/cci_mpf_dbg_history_ctrl_if.sv
// Probe-side and history-buffer-write signals of the debug history controller.
// The controller uses the slave modport; the environment (probes plus buffer) uses master.
interface cci_mpf_dbg_history_ctrl_if #(
  parameter int N_CLIENTS          = 4,
  parameter int N_CLIENT_DATA_BITS = 28,
  parameter int N_ENTRIES          = 1024
);
  localparam int CW = $clog2(N_CLIENTS);
  localparam int IW = $clog2(N_ENTRIES);
  localparam int DW = N_CLIENT_DATA_BITS + CW;

  logic [N_CLIENTS-1:0]                    cl_valid;
  logic [N_CLIENTS*N_CLIENT_DATA_BITS-1:0] cl_data;
  logic [N_CLIENTS-1:0]                    cl_trigger;
  logic [N_CLIENTS-1:0]                    cl_ready;
  logic                                    hist_wr_en;
  logic [DW-1:0]                           hist_wr_data;
  logic [IW-1:0]                           hist_wr_idx;

  modport slave (
    input  cl_valid, cl_data, cl_trigger,
    output cl_ready, hist_wr_en, hist_wr_data, hist_wr_idx
  );

  modport master (
    output cl_valid, cl_data, cl_trigger,
    input  cl_ready, hist_wr_en, hist_wr_data, hist_wr_idx
  );
endinterface

// File: rtl/cci_mpf_dbg_history_ctrl.sv
// Merges non-stallable debug probes into one ring-mode history buffer write stream,
// with round-robin arbitration and an arm/trigger/post-trigger/freeze capture FSM.
module cci_mpf_dbg_history_ctrl #(
  parameter int  N_CLIENTS          = 4,
  parameter int  N_CLIENT_DATA_BITS = 28,
  parameter int  N_ENTRIES          = 1024,
  localparam int CW                 = $clog2(N_CLIENTS),
  localparam int IW                 = $clog2(N_ENTRIES)
) (
  input  logic                       clk,
  input  logic                       reset,
  cci_mpf_dbg_history_ctrl_if.slave  bus,
  input  logic                       ctl_arm,
  input  logic                       ctl_stop,
  input  logic [IW-1:0]              ctl_post_count,
  output logic [1:0]                 st_state,
  output logic [IW-1:0]              st_trig_idx,
  output logic                       st_wrapped,
  output logic [15:0]                st_dropped
);
  localparam int DW = N_CLIENT_DATA_BITS + CW;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_FROZEN = 2'd3} state_t;

  state_t                                      state_q, state_d;
  logic [IW-1:0]                               cnt_q, cnt_d;
  logic [IW-1:0]                               wptr_q, wptr_d;
  logic                                        wrapped_q, wrapped_d;
  logic [15:0]                                 dropped_q, dropped_d;
  logic [IW-1:0]                               trig_idx_q, trig_idx_d;
  logic [CW-1:0]                               rr_ptr_q, rr_ptr_d;
  logic [N_CLIENTS-1:0]                        held_q, held_d;
  logic [N_CLIENTS-1:0]                        slot_trig_q, slot_trig_d;
  logic [N_CLIENTS-1:0][N_CLIENT_DATA_BITS-1:0] slot_data_q, slot_data_d;
  logic                                        wr_en_q, wr_en_d;
  logic [IW-1:0]                               wr_idx_q, wr_idx_d;
  logic [DW-1:0]                               wr_data_q, wr_data_d;

  logic                 grant_vld;
  logic [CW-1:0]        grant_id;
  logic [N_CLIENTS-1:0] grant;
  logic                 active;
  logic                 take;
  logic [16:0]          drop_sum;
  int                   n_drop;

  // NOTE: combinational blocks assign every output a default first, so no latch can be inferred.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    grant     = '0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      if (!grant_vld && held_q[(int'(rr_ptr_q) + k) % N_CLIENTS]) begin
        grant_vld = 1'b1;
        grant_id  = CW'((int'(rr_ptr_q) + k) % N_CLIENTS);
      end
    end
    grant[grant_id] = grant_vld;
  end

  assign bus.cl_ready = ~held_q | grant;
  assign active       = (state_q == S_ARMED) || (state_q == S_POST);
  // A grant in the stop cycle is dropped rather than written.
  assign take         = active && grant_vld && !ctl_stop;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wptr_d      = wptr_q;
    wrapped_d   = wrapped_q;
    trig_idx_d  = trig_idx_q;
    rr_ptr_d    = rr_ptr_q;
    held_d      = held_q & ~grant;
    slot_trig_d = slot_trig_q;
    slot_data_d = slot_data_q;
    wr_en_d     = 1'b0;
    wr_idx_d    = wr_idx_q;
    wr_data_d   = wr_data_q;
    n_drop      = 0;

    if (active) begin
      for (int i = 0; i < N_CLIENTS; i++) begin
        if (bus.cl_valid[i] && bus.cl_ready[i]) begin
          held_d[i]      = 1'b1;
          slot_trig_d[i] = bus.cl_trigger[i];
          slot_data_d[i] = bus.cl_data[i*N_CLIENT_DATA_BITS +: N_CLIENT_DATA_BITS];
        end else if (bus.cl_valid[i]) begin
          n_drop = n_drop + 1;
        end
      end
    end
    drop_sum  = {1'b0, dropped_q} + 17'(n_drop);
    dropped_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    if (take) begin
      wr_en_d   = 1'b1;
      wr_idx_d  = wptr_q;
      wr_data_d = {grant_id, slot_data_q[grant_id]};
      wptr_d    = wptr_q + 1'b1;
      rr_ptr_d  = (int'(grant_id) == N_CLIENTS - 1) ? '0 : grant_id + 1'b1;
      if (wptr_q == IW'(N_ENTRIES - 1)) wrapped_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_FROZEN: begin
        if (ctl_arm && !ctl_stop) begin
          state_d   = S_ARMED;
          wptr_d    = '0;
          wrapped_d = 1'b0;
          dropped_d = '0;
          cnt_d     = ctl_post_count;
        end
      end
      S_ARMED: begin
        if (ctl_stop) begin
          state_d = S_FROZEN;
        end else if (take && slot_trig_q[grant_id]) begin
          trig_idx_d = wptr_q;
          state_d    = (cnt_q == '0) ? S_FROZEN : S_POST;
        end
      end
      default: begin
        if (ctl_stop) begin
          state_d = S_FROZEN;
        end else if (take) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == IW'(1)) state_d = S_FROZEN;
        end
      end
    endcase

    if (state_d == S_IDLE || state_d == S_FROZEN) held_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wptr_q      <= '0;
      wrapped_q   <= 1'b0;
      dropped_q   <= '0;
      trig_idx_q  <= '0;
      rr_ptr_q    <= '0;
      held_q      <= '0;
      slot_trig_q <= '0;
      wr_en_q     <= 1'b0;
      wr_idx_q    <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wptr_q      <= wptr_d;
      wrapped_q   <= wrapped_d;
      dropped_q   <= dropped_d;
      trig_idx_q  <= trig_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      held_q      <= held_d;
      slot_trig_q <= slot_trig_d;
      wr_en_q     <= wr_en_d;
      wr_idx_q    <= wr_idx_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // NOTE: slot payloads are qualified by held_q, so this storage needs no reset.
  always_ff @(posedge clk) begin
    slot_data_q <= slot_data_d;
  end

  assign bus.hist_wr_en   = wr_en_q;
  assign bus.hist_wr_idx  = wr_idx_q;
  assign bus.hist_wr_data = wr_data_q;
  assign st_state         = state_q;
  assign st_trig_idx      = trig_idx_q;
  assign st_wrapped       = wrapped_q;
  assign st_dropped       = dropped_q;
endmodule

// File: tb/tb_cci_mpf_dbg_history_ctrl.sv
// Directed checks of the debug history controller with a 16-entry ring.
module tb_cci_mpf_dbg_history_ctrl;
  localparam int NC = 4;
  localparam int PB = 28;
  localparam int NE = 16;
  localparam int IW = 4;
  localparam int DW = 30;

  logic          clk = 1'b0;
  logic          reset;
  logic          ctl_arm;
  logic          ctl_stop;
  logic [IW-1:0] ctl_post_count;
  logic [1:0]    st_state;
  logic [IW-1:0] st_trig_idx;
  logic          st_wrapped;
  logic [15:0]   st_dropped;

  int n_checks = 0;
  int n_bad    = 0;
  int base;
  logic [IW+DW-1:0] wq[$];

  cci_mpf_dbg_history_ctrl_if #(.N_CLIENTS(NC), .N_CLIENT_DATA_BITS(PB), .N_ENTRIES(NE)) bus ();

  cci_mpf_dbg_history_ctrl #(.N_CLIENTS(NC), .N_CLIENT_DATA_BITS(PB), .N_ENTRIES(NE)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus.slave),
    .ctl_arm        (ctl_arm),
    .ctl_stop       (ctl_stop),
    .ctl_post_count (ctl_post_count),
    .st_state       (st_state),
    .st_trig_idx    (st_trig_idx),
    .st_wrapped     (st_wrapped),
    .st_dropped     (st_dropped)
  );

  always #5 clk = ~clk;

  // Write log sampled on the falling edge; entry = {idx, data}.
  always @(negedge clk) begin
    if (bus.hist_wr_en) wq.push_back({bus.hist_wr_idx, bus.hist_wr_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    ctl_arm        = 1'b0;
    ctl_stop       = 1'b0;
    ctl_post_count = '0;
    bus.cl_valid   = '0;
    bus.cl_trigger = '0;
    bus.cl_data    = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic arm(input logic [IW-1:0] post);
    ctl_post_count = post;
    ctl_arm        = 1'b1;
    tick();
    ctl_arm = 1'b0;
  endtask

  task automatic check_entry(input string tag, input int n, input logic [IW-1:0] idx, input logic [DW-1:0] data);
    logic [IW+DW-1:0] e;
    if (n >= wq.size()) begin
      check({tag, "_present"}, 32'(wq.size()), 32'(n + 1));
    end else begin
      e = wq[n];
      check({tag, "_idx"}, 32'(e[IW+DW-1:DW]), 32'(idx));
      check({tag, "_data"}, 32'(e[DW-1:0]), 32'(data));
    end
  endtask

  initial begin
    do_reset();
    check("rst_state", 32'(st_state), 32'd0);
    check("rst_wr_en", 32'(bus.hist_wr_en), 32'd0);
    check("rst_wr_idx", 32'(bus.hist_wr_idx), 32'd0);
    check("rst_wr_data", 32'(bus.hist_wr_data), 32'd0);
    check("rst_ready", 32'(bus.cl_ready), 32'hF);
    check("rst_dropped", 32'(st_dropped), 32'd0);
    check("rst_wrapped", 32'(st_wrapped), 32'd0);
    check("rst_trig_idx", 32'(st_trig_idx), 32'd0);

    // Single sample from client 1: two-cycle latency, one write.
    arm(4'd2);
    check("t1_armed", 32'(st_state), 32'd1);
    bus.cl_valid = 4'b0010;
    bus.cl_data[1*PB +: PB] = 28'h0000ABC;
    tick();
    bus.cl_valid = '0;
    check("t1_no_write_yet", 32'(bus.hist_wr_en), 32'd0);
    tick();
    check("t1_wr_en", 32'(bus.hist_wr_en), 32'd1);
    check("t1_wr_idx", 32'(bus.hist_wr_idx), 32'd0);
    check("t1_wr_data", 32'(bus.hist_wr_data), 32'h1000_0ABC);
    tick();
    check("t1_single", 32'(bus.hist_wr_en), 32'd0);

    // All four clients in one cycle: drained 0,1,2,3 on consecutive cycles.
    do_reset();
    arm(4'd5);
    base = wq.size();
    bus.cl_valid = 4'hF;
    for (int i = 0; i < NC; i++) bus.cl_data[i*PB +: PB] = 28'(32'h100 + i);
    tick();
    bus.cl_valid = '0;
    repeat (6) tick();
    check("t2_count", 32'(wq.size() - base), 32'd4);
    for (int i = 0; i < NC; i++)
      check_entry($sformatf("t2_w%0d", i), base + i, IW'(i), {2'(i), 28'(32'h100 + i)});
    check("t2_dropped", 32'(st_dropped), 32'd0);

    // All clients valid for 8 cycles: strict rotation, 3 drops per cycle after the first.
    do_reset();
    arm(4'd5);
    base = wq.size();
    bus.cl_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NC; i++) bus.cl_data[i*PB +: PB] = 28'(c * 16 + i);
      tick();
    end
    bus.cl_valid = '0;
    repeat (6) tick();
    check("t3_count", 32'(wq.size() - base), 32'd11);
    for (int i = 0; i < 11 && base + i < wq.size(); i++) begin
      check($sformatf("t3_id%0d", i), 32'(wq[base+i][DW-1:PB]), 32'(i % 4));
      check($sformatf("t3_idx%0d", i), 32'(wq[base+i][IW+DW-1:DW]), 32'(i));
    end
    check("t3_dropped", 32'(st_dropped), 32'd21);

    // Trigger on 6th write with post_count=3: writes idx 0..8, then frozen.
    do_reset();
    arm(4'd3);
    base = wq.size();
    bus.cl_valid = 4'b0001;
    for (int s = 0; s < 12; s++) begin
      bus.cl_data[PB-1:0] = 28'(s);
      bus.cl_trigger      = (s == 5) ? 4'b0001 : 4'b0000;
      tick();
      if (s == 7) check("t4_post", 32'(st_state), 32'd2);
    end
    bus.cl_valid   = '0;
    bus.cl_trigger = '0;
    repeat (4) tick();
    check("t4_count", 32'(wq.size() - base), 32'd9);
    check_entry("t4_trig_entry", base + 5, 4'd5, 30'd5);
    check_entry("t4_last", base + 8, 4'd8, 30'd8);
    check("t4_trig_idx", 32'(st_trig_idx), 32'd5);
    check("t4_frozen", 32'(st_state), 32'd3);
    check("t4_wr_en_idle", 32'(bus.hist_wr_en), 32'd0);
    check("t4_dropped", 32'(st_dropped), 32'd0);

    // 20 samples into a 16-entry ring: wrap, then stop and re-arm.
    do_reset();
    arm(4'd0);
    base = wq.size();
    bus.cl_valid = 4'b0001;
    for (int s = 0; s < 20; s++) begin
      bus.cl_data[PB-1:0] = 28'(32'h200 + s);
      tick();
    end
    bus.cl_valid = '0;
    repeat (3) tick();
    check("t5_count", 32'(wq.size() - base), 32'd20);
    check_entry("t5_w15", base + 15, 4'd15, 30'h20F);
    check_entry("t5_w16", base + 16, 4'd0, 30'h210);
    check_entry("t5_last", base + 19, 4'd3, 30'h213);
    check("t5_wrapped", 32'(st_wrapped), 32'd1);
    ctl_stop = 1'b1;
    tick();
    ctl_stop = 1'b0;
    check("t5_stop", 32'(st_state), 32'd3);
    arm(4'd0);
    check("t5_rearm", 32'(st_state), 32'd1);
    check("t5_wrap_clr", 32'(st_wrapped), 32'd0);
    base = wq.size();
    bus.cl_valid = 4'b0100;
    bus.cl_data[2*PB +: PB] = 28'h0000077;
    tick();
    bus.cl_valid = '0;
    repeat (3) tick();
    check("t5_count2", 32'(wq.size() - base), 32'd1);
    check_entry("t5_restart", base, 4'd0, {2'd2, 28'h0000077});

    // Arm with stop from FROZEN stays frozen; reset in POST clears everything.
    ctl_stop = 1'b1;
    tick();
    check("t6_frozen", 32'(st_state), 32'd3);
    ctl_arm = 1'b1;
    tick();
    ctl_arm  = 1'b0;
    ctl_stop = 1'b0;
    check("t6_arm_stop", 32'(st_state), 32'd3);
    arm(4'd5);
    bus.cl_valid   = 4'b1000;
    bus.cl_trigger = 4'b1000;
    bus.cl_data[3*PB +: PB] = 28'h0000055;
    tick();
    bus.cl_valid   = '0;
    bus.cl_trigger = '0;
    tick();
    check("t6_post", 32'(st_state), 32'd2);
    check("t6_wr_en", 32'(bus.hist_wr_en), 32'd1);
    reset = 1'b1;
    tick();
    check("t6_rst_state", 32'(st_state), 32'd0);
    check("t6_rst_wr_en", 32'(bus.hist_wr_en), 32'd0);
    check("t6_rst_wr_data", 32'(bus.hist_wr_data), 32'd0);
    check("t6_rst_ready", 32'(bus.cl_ready), 32'hF);
    check("t6_rst_trig", 32'(st_trig_idx), 32'd0);
    reset = 1'b0;
    tick();

    // Drop counter saturates at 16'hFFFF.
    arm(4'd0);
    bus.cl_valid = 4'hF;
    repeat (22000) tick();
    bus.cl_valid = '0;
    tick();
    check("t7_saturate", 32'(st_dropped), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
